// File: rtl/data_mem_strb.sv
// data_mem_strb
//   Single-port-per-channel word memory behind a simplified AXI-style
//   write channel (address/data/strobe in one beat, separate response
//   handshake) and read channel (address handshake, one-cycle registered
//   read data). Byte-lane strobes, SLVERR on misaligned or out-of-range
//   addresses, read-before-write on same-edge collisions.
//
// Ports
//   clock                      rising-edge clock
//   resetN                     synchronous active-low reset
//   ramAxiWrite{Address,Data,Strobe,Valid} / ramAxiWriteReady   write request
//   ramAxiWriteResp, ramAxiWriteRespValid / ramAxiWriteRespReady write response
//   ramAxiReadAddress, ramAxiReadAddrValid / ramAxiReadAddrReady read address
//   ramAxiReadData, ramAxiReadResp,
//   ramAxiReadDataValid / ramAxiReadDataReady                    read data
module data_mem_strb #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic [31:0]               ramAxiWriteAddress,
  input  logic [DATA_WIDTH-1:0]     ramAxiWriteData,
  input  logic [DATA_WIDTH/8-1:0]   ramAxiWriteStrobe,
  input  logic                      ramAxiWriteValid,
  output logic                      ramAxiWriteReady,
  output logic [1:0]                ramAxiWriteResp,
  output logic                      ramAxiWriteRespValid,
  input  logic                      ramAxiWriteRespReady,
  input  logic [31:0]               ramAxiReadAddress,
  input  logic                      ramAxiReadAddrValid,
  output logic                      ramAxiReadAddrReady,
  output logic [DATA_WIDTH-1:0]     ramAxiReadData,
  output logic [1:0]                ramAxiReadResp,
  output logic                      ramAxiReadDataValid,
  input  logic                      ramAxiReadDataReady
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH_WORDS);
  localparam int AW    = OFFS + IDXW;
  localparam logic [63:0] BYTE_SPAN = 64'(DEPTH_WORDS) * 64'(BYTES);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Full 32-bit compare so that high address bits never alias onto the array.
  function automatic logic addr_legal(input logic [31:0] a);
    return (a[OFFS-1:0] == '0) && ({32'h0, a} < BYTE_SPAN);
  endfunction

  // ---------------- write channel ----------------
  logic            wr_resp_valid_q, wr_resp_valid_d;
  logic [1:0]      wr_resp_q, wr_resp_d;
  logic            wr_fire, wr_legal;
  logic [IDXW-1:0] wr_idx;

  assign ramAxiWriteReady = resetN && !wr_resp_valid_q;
  assign wr_fire          = ramAxiWriteValid && ramAxiWriteReady;
  assign wr_legal         = addr_legal(ramAxiWriteAddress);
  assign wr_idx           = ramAxiWriteAddress[AW-1:OFFS];

  always_comb begin
    wr_resp_valid_d = wr_resp_valid_q;
    wr_resp_d       = wr_resp_q;
    if (wr_fire) begin
      wr_resp_valid_d = 1'b1;
      wr_resp_d       = wr_legal ? RESP_OKAY : RESP_SLVERR;
    end else if (wr_resp_valid_q && ramAxiWriteRespReady) begin
      wr_resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      wr_resp_valid_q <= 1'b0;
      wr_resp_q       <= RESP_OKAY;
    end else begin
      wr_resp_valid_q <= wr_resp_valid_d;
      wr_resp_q       <= wr_resp_d;
    end
  end

  // Array is deliberately not reset; wr_fire is already gated by resetN.
  always_ff @(posedge clock) begin
    if (wr_fire && wr_legal) begin
      for (int i = 0; i < BYTES; i++) begin
        if (ramAxiWriteStrobe[i]) begin
          mem[wr_idx][8*i +: 8] <= ramAxiWriteData[8*i +: 8];
        end
      end
    end
  end

  assign ramAxiWriteResp      = wr_resp_q;
  assign ramAxiWriteRespValid = wr_resp_valid_q;

  // ---------------- read channel ----------------
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [1:0]            rd_resp_q, rd_resp_d;
  logic                  rd_fire, rd_legal;
  logic [IDXW-1:0]       rd_idx;

  assign ramAxiReadAddrReady = resetN && (!rd_valid_q || ramAxiReadDataReady);
  assign rd_fire             = ramAxiReadAddrValid && ramAxiReadAddrReady;
  assign rd_legal            = addr_legal(ramAxiReadAddress);
  assign rd_idx              = ramAxiReadAddress[AW-1:OFFS];

  // The array read sees the value before any same-edge write lands,
  // which gives read-before-write on collisions.
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_resp_d  = rd_resp_q;
    if (rd_fire) begin
      rd_valid_d = 1'b1;
      if (rd_legal) begin
        rd_data_d = mem[rd_idx];
        rd_resp_d = RESP_OKAY;
      end else begin
        rd_data_d = '0;
        rd_resp_d = RESP_SLVERR;
      end
    end else if (rd_valid_q && ramAxiReadDataReady) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_resp_q  <= RESP_OKAY;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_resp_q  <= rd_resp_d;
    end
  end

  assign ramAxiReadData      = rd_data_q;
  assign ramAxiReadResp      = rd_resp_q;
  assign ramAxiReadDataValid = rd_valid_q;

endmodule

// File: tb/tb_data_mem_strb.sv
// Directed bench for data_mem_strb (DATA_WIDTH 32, DEPTH_WORDS 1024).
// Inputs change and outputs are sampled on the falling edge.
module tb_data_mem_strb;

  logic        clock;
  logic        resetN;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  w_resp;
  logic        w_resp_valid;
  logic        w_resp_ready;
  logic [31:0] r_addr;
  logic        r_addr_valid;
  logic        r_addr_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_data_valid;
  logic        r_data_ready;

  int total = 0;
  int bad   = 0;

  data_mem_strb #(.DATA_WIDTH(32), .DEPTH_WORDS(1024)) dut (
    .clock                (clock),
    .resetN               (resetN),
    .ramAxiWriteAddress   (w_addr),
    .ramAxiWriteData      (w_data),
    .ramAxiWriteStrobe    (w_strb),
    .ramAxiWriteValid     (w_valid),
    .ramAxiWriteReady     (w_ready),
    .ramAxiWriteResp      (w_resp),
    .ramAxiWriteRespValid (w_resp_valid),
    .ramAxiWriteRespReady (w_resp_ready),
    .ramAxiReadAddress    (r_addr),
    .ramAxiReadAddrValid  (r_addr_valid),
    .ramAxiReadAddrReady  (r_addr_ready),
    .ramAxiReadData       (r_data),
    .ramAxiReadResp       (r_resp),
    .ramAxiReadDataValid  (r_data_valid),
    .ramAxiReadDataReady  (r_data_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single write, response held one extra cycle before being taken.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] exp_resp);
    w_addr = a; w_data = d; w_strb = s; w_valid = 1'b1; w_resp_ready = 1'b0;
    step();
    w_valid = 1'b0;
    chk("wr_resp_valid_rise", 64'(w_resp_valid), 64'd1);
    chk("wr_resp", 64'(w_resp), 64'(exp_resp));
    chk("wr_ready_blocked", 64'(w_ready), 64'd0);
    step();
    chk("wr_resp_hold_valid", 64'(w_resp_valid), 64'd1);
    chk("wr_resp_hold", 64'(w_resp), 64'(exp_resp));
    w_resp_ready = 1'b1;
    step();
    w_resp_ready = 1'b0;
    chk("wr_resp_valid_clear", 64'(w_resp_valid), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
    r_addr = a; r_addr_valid = 1'b1; r_data_ready = 1'b1;
    step();
    r_addr_valid = 1'b0;
    chk("rd_valid", 64'(r_data_valid), 64'd1);
    chk("rd_data", 64'(r_data), 64'(exp_data));
    chk("rd_resp", 64'(r_resp), 64'(exp_resp));
    step();
    chk("rd_valid_clear", 64'(r_data_valid), 64'd0);
  endtask

  initial begin
    resetN = 1'b0;
    w_addr = '0; w_data = '0; w_strb = '0; w_valid = 1'b0; w_resp_ready = 1'b0;
    r_addr = '0; r_addr_valid = 1'b0; r_data_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_wr_ready", 64'(w_ready), 64'd0);
    chk("rst_rd_addr_ready", 64'(r_addr_ready), 64'd0);
    chk("rst_wr_resp_valid", 64'(w_resp_valid), 64'd0);
    chk("rst_rd_valid", 64'(r_data_valid), 64'd0);
    chk("rst_rd_data", 64'(r_data), 64'd0);
    chk("rst_wr_resp", 64'(w_resp), 64'd0);
    chk("rst_rd_resp", 64'(r_resp), 64'd0);
    resetN = 1'b1;
    #1;
    chk("post_rst_wr_ready", 64'(w_ready), 64'd1);
    chk("post_rst_rd_addr_ready", 64'(r_addr_ready), 64'd1);
    @(negedge clock);

    // Byte-lane writes
    do_write(32'h10, 32'h1122_3344, 4'hF, 2'b00);
    do_write(32'h10, 32'hAABB_CCDD, 4'b0101, 2'b00);
    do_read(32'h10, 32'h11BB_33DD, 2'b00);
    // Zero strobe: OKAY, nothing modified
    do_write(32'h10, 32'hFFFF_FFFF, 4'h0, 2'b00);
    do_read(32'h10, 32'h11BB_33DD, 2'b00);

    // Illegal accesses
    do_write(32'h0, 32'hCAFE_F00D, 4'hF, 2'b00);
    do_write(32'h1002, 32'h1234_5678, 4'hF, 2'b10);
    do_write(32'h1000, 32'h8765_4321, 4'hF, 2'b10);
    do_write(32'h0001_0000, 32'h5555_5555, 4'hF, 2'b10);
    do_read(32'h1000, 32'h0, 2'b10);
    do_read(32'h2, 32'h0, 2'b10);
    do_read(32'h0, 32'hCAFE_F00D, 2'b00);
    // Last legal word
    do_write(32'hFFC, 32'h0F0F_1234, 4'hF, 2'b00);
    do_read(32'hFFC, 32'h0F0F_1234, 2'b00);

    // Backpressure
    do_write(32'h20, 32'h5A5A_1234, 4'hF, 2'b00);
    do_write(32'h24, 32'h0BAD_CAFE, 4'hF, 2'b00);
    r_addr = 32'h20; r_addr_valid = 1'b1; r_data_ready = 1'b0;
    step();
    r_addr = 32'h24;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(r_data_valid), 64'd1);
      chk("bp_data", 64'(r_data), 64'h5A5A_1234);
      chk("bp_resp", 64'(r_resp), 64'd0);
      chk("bp_addr_ready", 64'(r_addr_ready), 64'd0);
      step();
    end
    r_data_ready = 1'b1;
    #1;
    chk("bp_release_addr_ready", 64'(r_addr_ready), 64'd1);
    step();
    r_addr_valid = 1'b0;
    chk("bp_next_valid", 64'(r_data_valid), 64'd1);
    chk("bp_next_data", 64'(r_data), 64'h0BAD_CAFE);
    step();
    chk("bp_next_clear", 64'(r_data_valid), 64'd0);

    // Same-edge read and write to one word
    do_write(32'h40, 32'h0, 4'hF, 2'b00);
    w_addr = 32'h40; w_data = 32'hDEAD_BEEF; w_strb = 4'hF; w_valid = 1'b1;
    r_addr = 32'h40; r_addr_valid = 1'b1; r_data_ready = 1'b1;
    step();
    w_valid = 1'b0; r_addr_valid = 1'b0;
    chk("coll_rd_old", 64'(r_data), 64'h0);
    chk("coll_rd_valid", 64'(r_data_valid), 64'd1);
    chk("coll_wr_resp_valid", 64'(w_resp_valid), 64'd1);
    w_resp_ready = 1'b1;
    step();
    w_resp_ready = 1'b0;
    do_read(32'h40, 32'hDEAD_BEEF, 2'b00);

    // Throughput: 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      do_write(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 2'b00);
    end
    // A write left pending across the coming reset
    w_addr = 32'h200; w_data = 32'h0000_0077; w_strb = 4'hF; w_valid = 1'b1;
    w_resp_ready = 1'b0;
    r_addr = 32'h100; r_addr_valid = 1'b1; r_data_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      w_valid = 1'b0;
      chk("tp_valid", 64'(r_data_valid), 64'd1);
      chk("tp_data", 64'(r_data), 64'(32'hA000_0000 + 32'(i)));
      r_addr = 32'h100 + 32'(4 * ((i + 1) % 8));
    end
    chk("tp_wr_pending", 64'(w_resp_valid), 64'd1);

    // Reset mid-stream; a write held valid during reset must not land
    w_addr = 32'h200; w_data = 32'h0000_0099; w_valid = 1'b1;
    resetN = 1'b0;
    #1;
    chk("mid_rst_rd_addr_ready", 64'(r_addr_ready), 64'd0);
    chk("mid_rst_wr_ready", 64'(w_ready), 64'd0);
    step();
    chk("mid_rst_rd_valid", 64'(r_data_valid), 64'd0);
    chk("mid_rst_wr_resp_valid", 64'(w_resp_valid), 64'd0);
    chk("mid_rst_rd_data", 64'(r_data), 64'd0);
    chk("mid_rst_rd_addr_ready2", 64'(r_addr_ready), 64'd0);
    step();
    chk("mid_rst_wr_ready2", 64'(w_ready), 64'd0);
    w_valid = 1'b0; r_addr_valid = 1'b0;
    resetN = 1'b1;
    #1;
    chk("rel_rd_addr_ready", 64'(r_addr_ready), 64'd1);
    chk("rel_wr_ready", 64'(w_ready), 64'd1);
    @(negedge clock);
    do_read(32'h200, 32'h0000_0077, 2'b00);
    do_read(32'h100, 32'hA000_0000, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
